// File: rtl/fp_mac.sv
// FP16 multiply-accumulate: three register stages (operands, product, sum) with
// round-to-nearest-even, flush-to-zero subnormals and canonical NaN.
module fp_mac (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  input  logic [15:0] opADD,
  input  logic        enA,
  input  logic        enB,
  input  logic        enADD,
  input  logic        en_Mul_A,
  input  logic        en_Mul_B,
  input  logic        en_Add_A,
  input  logic        en_Add_B,
  output logic [15:0] out_o,
  output logic        val_o
);

  localparam logic [15:0] QNAN = 16'h7E00;

  logic [15:0] a_q, a_d, b_q, b_d, add_q, add_d, mul_q, mul_d, out_q, out_d;
  logic        val_q, val_d;

  // Round a normalized 11-bit significand, then resolve overflow / flush-to-zero.
  function automatic logic [15:0] rnd_pack(input logic s, input logic signed [7:0] e,
                                           input logic [10:0] m, input logic g,
                                           input logic r, input logic st);
    logic [11:0]        mr;
    logic signed [7:0]  ef;
    mr = {1'b0, m} + {11'b0, g & (r | st | m[0])};
    ef = e;
    if (mr[11]) begin
      mr = mr >> 1;
      ef = ef + 8'sd1;
    end
    if (ef >= 8'sd31)     rnd_pack = {s, 5'h1F, 10'h000};
    else if (ef <= 8'sd0) rnd_pack = {s, 15'h0000};
    else                  rnd_pack = {s, ef[4:0], mr[9:0]};
  endfunction

  function automatic logic [15:0] fp_mul(input logic [15:0] a, input logic [15:0] b);
    logic               s, na, nb, ia, ib, za, zb;
    logic [21:0]        p;
    logic signed [7:0]  e;
    s  = a[15] ^ b[15];
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    ia = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    ib = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    za = (a[14:10] == 5'h00);
    zb = (b[14:10] == 5'h00);
    p  = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e  = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
    if (na || nb || (ia && zb) || (ib && za)) fp_mul = QNAN;
    else if (ia || ib)                        fp_mul = {s, 5'h1F, 10'h000};
    else if (za || zb)                        fp_mul = {s, 15'h0000};
    else if (p[21])
      fp_mul = rnd_pack(s, e + 8'sd1, p[21:11], p[10], p[9], |p[8:0]);
    else
      fp_mul = rnd_pack(s, e, p[20:10], p[9], p[8], |p[7:0]);
  endfunction

  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic               na, nb, ia, ib, za, zb;
    logic [15:0]        x, y;
    logic [4:0]         d;
    logic [13:0]        mx, my, sh, mask, m14;
    logic [14:0]        sum;
    logic [3:0]         pos, shl;
    logic signed [7:0]  e;
    na = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
    ia = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
    ib = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
    za = (a[14:10] == 5'h00);
    zb = (b[14:10] == 5'h00);
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    d    = x[14:10] - y[14:10];
    mx   = {1'b1, x[9:0], 3'b000};
    my   = {1'b1, y[9:0], 3'b000};
    mask = (14'd1 << d) - 14'd1;
    if (d >= 5'd14) sh = 14'd1;
    else            sh = (my >> d) | {13'b0, |(my & mask)};
    e    = $signed({3'b000, x[14:10]});
    sum  = {1'b0, mx} + {1'b0, sh};
    m14  = mx - sh;
    pos  = 4'd0;
    for (int i = 0; i < 14; i++)
      if (m14[i]) pos = i[3:0];
    shl  = 4'd13 - pos;
    if (na || nb || (ia && ib && (a[15] != b[15]))) fp_add = QNAN;
    else if (ia)                                    fp_add = a;
    else if (ib)                                    fp_add = b;
    else if (za && zb)                              fp_add = {a[15] & b[15], 15'h0000};
    else if (za)                                    fp_add = b;
    else if (zb)                                    fp_add = a;
    else if (x[15] == y[15]) begin
      // Carry out of the significand: shift right, keep the lost bit as sticky.
      if (sum[14]) begin
        m14 = sum[14:1];
        fp_add = rnd_pack(x[15], e + 8'sd1, m14[13:3], m14[2], m14[1], m14[0] | sum[0]);
      end else begin
        m14 = sum[13:0];
        fp_add = rnd_pack(x[15], e, m14[13:3], m14[2], m14[1], m14[0]);
      end
    end
    else if (m14 == 14'd0)                          fp_add = 16'h0000;
    else begin
      m14 = m14 << shl;
      fp_add = rnd_pack(x[15], e - $signed({4'b0000, shl}), m14[13:3], m14[2], m14[1], m14[0]);
    end
  endfunction

  always_comb begin
    a_d   = enA   ? opA   : a_q;
    b_d   = enB   ? opB   : b_q;
    add_d = enADD ? opADD : add_q;
    mul_d = (en_Mul_A && en_Mul_B) ? fp_mul(a_q, b_q)     : mul_q;
    out_d = (en_Add_A && en_Add_B) ? fp_add(mul_q, add_q) : out_q;
    val_d = en_Add_A && en_Add_B;
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      add_q <= 16'h0000;
      mul_q <= 16'h0000;
      out_q <= 16'h0000;
      val_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      add_q <= add_d;
      mul_q <= mul_d;
      out_q <= out_d;
      val_q <= val_d;
    end
  end

  assign out_o = out_q;
  assign val_o = val_q;

endmodule

// File: tb/tb_fp_mac.sv
// Directed bench for fp_mac: hand-computed FP16 results checked per scenario.
module tb_fp_mac;

  logic        clk, rst_n;
  logic [15:0] opA, opB, opADD;
  logic        enA, enB, enADD, en_Mul_A, en_Mul_B, en_Add_A, en_Add_B;
  logic [15:0] out_o;
  logic        val_o;
  int          total, bad;

  fp_mac dut (
    .clk(clk), .rst_n(rst_n), .opA(opA), .opB(opB), .opADD(opADD),
    .enA(enA), .enB(enB), .enADD(enADD),
    .en_Mul_A(en_Mul_A), .en_Mul_B(en_Mul_B),
    .en_Add_A(en_Add_A), .en_Add_B(en_Add_B),
    .out_o(out_o), .val_o(val_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mac(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    opA = a; opB = b; opADD = c;
    enA = 1'b1; enB = 1'b1; enADD = 1'b1;
    tick;
    enA = 1'b0; enB = 1'b0; enADD = 1'b0;
    en_Mul_A = 1'b1; en_Mul_B = 1'b1;
    tick;
    en_Mul_A = 1'b0; en_Mul_B = 1'b0;
    en_Add_A = 1'b1; en_Add_B = 1'b1;
    tick;
    en_Add_A = 1'b0; en_Add_B = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (out_o !== 16'h0000) begin bad++; $display("FAIL reset_out: got %h want 0000", out_o); end
    total++;
    if (val_o !== 1'b0) begin bad++; $display("FAIL reset_val: got %b want 0", val_o); end
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    total++;
    if (out_o !== 16'h0000 || val_o !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got %h/%b want 0000/0", out_o, val_o);
    end
  endtask

  task automatic test_basic;
    run_mac(16'h4000, 16'h4200, 16'h3800);
    total++;
    if (out_o !== 16'h4680) begin bad++; $display("FAIL basic_out: got %h want 4680", out_o); end
    total++;
    if (val_o !== 1'b1) begin bad++; $display("FAIL basic_val: got %b want 1", val_o); end
    tick;
    total++;
    if (val_o !== 1'b0) begin bad++; $display("FAIL basic_val_drop: got %b want 0", val_o); end
  endtask

  task automatic test_hold;
    run_mac(16'h3C00, 16'h4000, 16'h4200);
    total++;
    if (out_o !== 16'h4500 || val_o !== 1'b1) begin
      bad++; $display("FAIL hold_first: got %h/%b want 4500/1", out_o, val_o);
    end
    opA = 16'h5555; opB = 16'h1234; opADD = 16'h7777;
    en_Mul_A = 1'b1;
    en_Add_B = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++;
      if (out_o !== 16'h4500 || val_o !== 1'b0) begin
        bad++; $display("FAIL hold_cycle%0d: got %h/%b want 4500/0", i, out_o, val_o);
      end
    end
    en_Mul_A = 1'b0;
    en_Add_B = 1'b0;
  endtask

  task automatic test_special;
    logic [15:0] va[13], vb[13], vc[13], vx[13];
    va = '{16'h7C00, 16'h7BFF, 16'h3C00, 16'hC000, 16'h8000, 16'h0001, 16'h0400,
           16'h7C00, 16'h7C00, 16'hFC00, 16'h7D00, 16'h3C00, 16'h4000};
    vb = '{16'h0000, 16'h4000, 16'h3C00, 16'h4200, 16'h3C00, 16'h3C00, 16'h3800,
           16'h3C00, 16'h3C00, 16'h4000, 16'h3C00, 16'h3C00, 16'h4200};
    vc = '{16'h1234, 16'h0000, 16'hBC00, 16'h0000, 16'h8000, 16'h8000, 16'h3C00,
           16'hC000, 16'hFC00, 16'h0000, 16'h3C00, 16'hB800, 16'h0001};
    vx = '{16'h7E00, 16'h7C00, 16'h0000, 16'hC600, 16'h8000, 16'h0000, 16'h3C00,
           16'h7C00, 16'h7E00, 16'hFC00, 16'h7E00, 16'h3800, 16'h4600};
    for (int i = 0; i < 13; i++) begin
      run_mac(va[i], vb[i], vc[i]);
      total++;
      if (out_o !== vx[i]) begin
        bad++;
        $display("FAIL special%0d (%h*%h+%h): got %h want %h", i, va[i], vb[i], vc[i], out_o, vx[i]);
      end
    end
  endtask

  task automatic test_rounding;
    logic [15:0] va[6], vb[6], vc[6], vx[6];
    // 0x1000 is exactly half an ulp of 1.0 (tie -> even); 0x1400 is a full ulp.
    va = '{16'h3C00, 16'h3C00, 16'h3C01, 16'h3C01, 16'h3E00, 16'h3C00};
    vb = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C01, 16'h3C01, 16'h4000};
    vc = '{16'h1000, 16'h1400, 16'h1000, 16'h0000, 16'h0000, 16'h4000};
    vx = '{16'h3C00, 16'h3C01, 16'h3C02, 16'h3C02, 16'h3E02, 16'h4400};
    for (int i = 0; i < 6; i++) begin
      run_mac(va[i], vb[i], vc[i]);
      total++;
      if (out_o !== vx[i]) begin
        bad++;
        $display("FAIL round%0d (%h*%h+%h): got %h want %h", i, va[i], vb[i], vc[i], out_o, vx[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_mac(16'h4000, 16'h4200, 16'h3800);
    opA = 16'h3C00; opB = 16'h3C00; opADD = 16'h4000;
    enA = 1'b1; enB = 1'b1; enADD = 1'b1;
    tick;
    enA = 1'b0; enB = 1'b0; enADD = 1'b0;
    en_Mul_A = 1'b1; en_Mul_B = 1'b1; en_Add_A = 1'b1; en_Add_B = 1'b1;
    tick;
    en_Mul_A = 1'b0; en_Mul_B = 1'b0;
    total++;
    if (out_o !== 16'h4800 || val_o !== 1'b1) begin
      bad++; $display("FAIL b2b_stale_mul: got %h/%b want 4800/1", out_o, val_o);
    end
    tick;
    en_Add_A = 1'b0; en_Add_B = 1'b0;
    total++;
    if (out_o !== 16'h4200) begin bad++; $display("FAIL b2b_new_mul: got %h want 4200", out_o); end
  endtask

  task automatic test_reset_mid;
    opA = 16'h4000; opB = 16'h4200; opADD = 16'h3800;
    enA = 1'b1; enB = 1'b1; enADD = 1'b1;
    tick;
    enA = 1'b0; enB = 1'b0; enADD = 1'b0;
    en_Mul_A = 1'b1; en_Mul_B = 1'b1;
    tick;
    en_Mul_A = 1'b0; en_Mul_B = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (out_o !== 16'h0000 || val_o !== 1'b0) begin
      bad++; $display("FAIL midreset_out: got %h/%b want 0000/0", out_o, val_o);
    end
    total++;
    if (dut.mul_q !== 16'h0000 || dut.add_q !== 16'h0000 || dut.a_q !== 16'h0000 || dut.b_q !== 16'h0000) begin
      bad++; $display("FAIL midreset_regs: got mul=%h add=%h a=%h b=%h want 0000", dut.mul_q, dut.add_q, dut.a_q, dut.b_q);
    end
    #1 rst_n = 1'b0;
    en_Add_A = 1'b1; en_Add_B = 1'b1;
    tick;
    en_Add_A = 1'b0; en_Add_B = 1'b0;
    total++;
    if (out_o !== 16'h0000 || val_o !== 1'b1) begin
      bad++; $display("FAIL midreset_add: got %h/%b want 0000/1", out_o, val_o);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    opA = 16'h0; opB = 16'h0; opADD = 16'h0;
    enA = 1'b0; enB = 1'b0; enADD = 1'b0;
    en_Mul_A = 1'b0; en_Mul_B = 1'b0; en_Add_A = 1'b0; en_Add_B = 1'b0;
    test_reset;
    test_basic;
    test_hold;
    test_special;
    test_rounding;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
